// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: bus types,
// I/O window offsets and CON_STATUS bit layout.
package data_mem_responder_pkg;

  localparam int WORD_SIZE = 32;

  typedef logic [31:0]          addr_t;
  typedef logic [WORD_SIZE-1:0] data_t;

  localparam logic [3:0] IO_CYCLE_OFS      = 4'h0;
  localparam logic [3:0] IO_GPIO_OFS       = 4'h4;
  localparam logic [3:0] IO_CON_DATA_OFS   = 4'h8;
  localparam logic [3:0] IO_CON_STATUS_OFS = 4'hC;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_MIS_BIT   = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;

  function automatic data_t pack_status(input logic full, input logic empty,
                                        input logic ovf, input logic mis,
                                        input logic [7:0] count);
    data_t s;
    s = {WORD_SIZE{1'b0}};
    s[ST_FULL_BIT]  = full;
    s[ST_EMPTY_BIT] = empty;
    s[ST_OVF_BIT]   = ovf;
    s[ST_MIS_BIT]   = mis;
    s[ST_COUNT_MSB:ST_COUNT_LSB] = count;
    return s;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory port plus GPIO and console stream of the responder.
// o_misalign exists only when DM_MISALIGN_CHK_EN is defined.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  addr_t      i_DM_addr;
  data_t      i_DM_wd;
  logic       i_DM_wen;
  logic       i_DM_ren;
  data_t      o_DM_rd;
  data_t      o_gpio;
  logic       o_con_valid;
  logic [7:0] o_con_data;
  logic       i_con_ready;
`ifdef DM_MISALIGN_CHK_EN
  logic       o_misalign;
`endif

  modport slave (
`ifdef DM_MISALIGN_CHK_EN
    output o_misalign,
`endif
    input  i_DM_addr, i_DM_wd, i_DM_wen, i_DM_ren, i_con_ready,
    output o_DM_rd, o_gpio, o_con_valid, o_con_data
  );

  modport master (
`ifdef DM_MISALIGN_CHK_EN
    input  o_misalign,
`endif
    output i_DM_addr, i_DM_wd, i_DM_wen, i_DM_ren, i_con_ready,
    input  o_DM_rd, o_gpio, o_con_valid, o_con_data
  );

endinterface

// File: rtl/data_mem_responder_con_fifo.sv
// Console byte FIFO: synchronous push/pop, no bypass, head masked to 0 when empty.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module con_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign o_full    = (count_r == DEPTH_C);
  assign o_empty   = (count_r == {(AW+1){1'b0}});
  assign o_count   = count_r;
  assign do_pop_s  = i_pop & ~o_empty;
  assign do_push_s = i_push & (~o_full | do_pop_s);
  assign o_dout    = o_empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; contents are discarded by reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= i_din;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for a single-cycle core: word RAM plus an I/O window
// (CYCLE, GPIO_OUT, console FIFO). Optional alignment checking: DM_MISALIGN_CHK_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int    RAM_DEPTH  = 1024,
  parameter int    FIFO_DEPTH = 8,
  parameter addr_t IO_BASE    = 32'hF000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  data_mem_responder_if.slave  bus
);

  localparam int    RAM_AW    = $clog2(RAM_DEPTH);
  localparam int    FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
  localparam addr_t RAM_BYTES = addr_t'(RAM_DEPTH * 4);

  data_t              ram_r [RAM_DEPTH];
  data_t              cycle_r;
  data_t              gpio_r;
  logic               ovf_r;
  logic               mis_s;
  logic               mis_flag_s;
  logic               ram_sel_s;
  logic               io_sel_s;
  logic [3:0]         io_ofs_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic               wr_ok_s;
  logic               rd_ok_s;
  logic               ram_we_s;
  logic               gpio_we_s;
  logic               status_we_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FIFO_CW-1:0] fifo_count_s;
  logic [7:0]         fifo_dout_s;
  logic               ovf_set_s;
  data_t              status_s;
  data_t              rd_s;

  assign ram_sel_s = (bus.i_DM_addr < RAM_BYTES);
  assign io_sel_s  = (bus.i_DM_addr[31:4] == IO_BASE[31:4]);
  assign io_ofs_s  = {bus.i_DM_addr[3:2], 2'b00};
  assign ram_idx_s = bus.i_DM_addr[RAM_AW+1:2];

`ifdef DM_MISALIGN_CHK_EN
  logic mis_flag_r;

  assign mis_s          = (bus.i_DM_wen | bus.i_DM_ren) & (bus.i_DM_addr[1:0] != 2'b00);
  assign bus.o_misalign = mis_s;
  assign mis_flag_s     = mis_flag_r;

  // Sticky MISALIGN flag, cleared by writing 1 to its CON_STATUS bit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mis_flag_r <= 1'b0;
    end else if (mis_s) begin
      mis_flag_r <= 1'b1;
    end else if (status_we_s && bus.i_DM_wd[ST_MIS_BIT]) begin
      mis_flag_r <= 1'b0;
    end
  end
`else
  assign mis_s      = 1'b0;
  assign mis_flag_s = 1'b0;
`endif

  assign wr_ok_s     = bus.i_DM_wen & ~mis_s;
  assign rd_ok_s     = bus.i_DM_ren & ~mis_s;
  assign ram_we_s    = wr_ok_s & ram_sel_s;
  assign gpio_we_s   = wr_ok_s & io_sel_s & (io_ofs_s == IO_GPIO_OFS);
  assign status_we_s = wr_ok_s & io_sel_s & (io_ofs_s == IO_CON_STATUS_OFS);
  assign push_s      = wr_ok_s & io_sel_s & (io_ofs_s == IO_CON_DATA_OFS);
  assign pop_s       = ~fifo_empty_s & bus.i_con_ready;
  // A simultaneous pop frees the slot, so only an unpaired push into a full FIFO drops.
  assign ovf_set_s   = push_s & fifo_full_s & ~pop_s;

  con_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (push_s),
    .i_din   (bus.i_DM_wd[7:0]),
    .i_pop   (pop_s),
    .o_dout  (fifo_dout_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s),
    .o_count (fifo_count_s)
  );

  assign bus.o_con_valid = ~fifo_empty_s;
  assign bus.o_con_data  = fifo_dout_s;
  assign bus.o_gpio      = gpio_r;
  assign bus.o_DM_rd     = rd_s;

  // RAM write port; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (ram_we_s) ram_r[ram_idx_s] <= bus.i_DM_wd;
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'h0000_0001;
    end
  end

  // GPIO output register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gpio_r <= 32'h0000_0000;
    end else if (gpio_we_s) begin
      gpio_r <= bus.i_DM_wd;
    end
  end

  // Sticky console overflow flag, cleared by writing 1 to its CON_STATUS bit.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (status_we_s && bus.i_DM_wd[ST_OVF_BIT]) begin
      ovf_r <= 1'b0;
    end
  end

  assign status_s = pack_status(fifo_full_s, fifo_empty_s, ovf_r, mis_flag_s,
                                8'(fifo_count_s));

  // Combinational read mux; reads never change state.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (rd_ok_s && ram_sel_s) begin
      rd_s = ram_r[ram_idx_s];
    end else if (rd_ok_s && io_sel_s) begin
      case (io_ofs_s)
        IO_CYCLE_OFS:      rd_s = cycle_r;
        IO_GPIO_OFS:       rd_s = gpio_r;
        IO_CON_STATUS_OFS: rd_s = status_s;
        default:           rd_s = 32'h0000_0000;
      endcase
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam addr_t IO_BASE = 32'hF000_0000;
  localparam addr_t A_CYC   = IO_BASE + 32'h0;
  localparam addr_t A_GPIO  = IO_BASE + 32'h4;
  localparam addr_t A_CON   = IO_BASE + 32'h8;
  localparam addr_t A_ST    = IO_BASE + 32'hC;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  data_t d;

  always #5 clk = ~clk;

  data_mem_responder_if bus_if();

  data_mem_responder #(
    .RAM_DEPTH  (1024),
    .FIFO_DEPTH (8),
    .IO_BASE    (IO_BASE)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (bus_if.slave)
  );

  task automatic wr(input addr_t a, input data_t v);
    bus_if.i_DM_addr = a;
    bus_if.i_DM_wd   = v;
    bus_if.i_DM_wen  = 1'b1;
    bus_if.i_DM_ren  = 1'b0;
    @(negedge clk);
    bus_if.i_DM_wen  = 1'b0;
  endtask

  task automatic rd(input addr_t a, output data_t v);
    bus_if.i_DM_addr = a;
    bus_if.i_DM_wen  = 1'b0;
    bus_if.i_DM_ren  = 1'b1;
    #1;
    v = bus_if.o_DM_rd;
    bus_if.i_DM_ren  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.i_DM_addr   = 32'h0;
    bus_if.i_DM_wd     = 32'h0;
    bus_if.i_DM_wen    = 1'b0;
    bus_if.i_DM_ren    = 1'b0;
    bus_if.i_con_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (bus_if.o_gpio !== 32'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", bus_if.o_gpio, 32'h0); end
    total++; if (bus_if.o_con_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.o_con_valid); end
    total++; if (bus_if.o_con_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus_if.o_con_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_CYC, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL cycle0 got=%0d exp=0", d); end
    repeat (5) @(negedge clk);
    rd(A_CYC, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL cycle5 got=%0d exp=5", d); end
    repeat (4) @(negedge clk);
    rd(A_CYC, d);
    total++; if (d !== 32'd9) begin bad++; $display("FAIL cycle9 got=%0d exp=9", d); end
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2); end
  endtask

  task automatic test_cycle_wrap();
    @(negedge clk);
    force dut.cycle_r = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_r;
    rd(A_CYC, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_max got=%h exp=ffffffff", d); end
    @(negedge clk);
    rd(A_CYC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%h exp=0", d); end
  endtask

  task automatic test_ram();
    @(negedge clk);
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", d); end
    bus_if.i_DM_addr = 32'h10;
    bus_if.i_DM_ren  = 1'b0;
    #1;
    total++; if (bus_if.o_DM_rd !== 32'h0) begin bad++; $display("FAIL ram_noren got=%h exp=0", bus_if.o_DM_rd); end
    rd(32'h0010_0000, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", d); end
    wr(32'h0, 32'h1111_1111);
    wr(32'h1000, 32'h2222_2222);
    rd(32'h0, d);
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL unmapped_wr got=%h exp=11111111", d); end
    wr(32'hFFC, 32'h3333_3333);
    rd(32'hFFC, d);
    total++; if (d !== 32'h3333_3333) begin bad++; $display("FAIL ram_top got=%h exp=33333333", d); end
`ifndef DM_MISALIGN_CHK_EN
    rd(32'h13, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_lowbits got=%h exp=deadbeef", d); end
`endif
  endtask

  task automatic test_rw_same();
    bus_if.i_DM_addr = 32'h10;
    bus_if.i_DM_wd   = 32'hCAFE_F00D;
    bus_if.i_DM_wen  = 1'b1;
    bus_if.i_DM_ren  = 1'b1;
    #1;
    total++; if (bus_if.o_DM_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_old got=%h exp=deadbeef", bus_if.o_DM_rd); end
    @(negedge clk);
    bus_if.i_DM_wen = 1'b0;
    bus_if.i_DM_ren = 1'b0;
    rd(32'h10, d);
    total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_new got=%h exp=cafef00d", d); end
  endtask

  task automatic test_gpio();
    wr(A_GPIO, 32'h0000_00A5);
    #1;
    total++; if (bus_if.o_gpio !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_out got=%h exp=a5", bus_if.o_gpio); end
    rd(A_GPIO, d);
    total++; if (d !== 32'h0000_00A5) begin bad++; $display("FAIL gpio_rd got=%h exp=a5", d); end
  endtask

  task automatic test_fifo_fill();
    bus_if.i_con_ready = 1'b0;
    @(negedge clk);
    bus_if.i_DM_addr = A_CON;
    bus_if.i_DM_wd   = 32'h41;
    bus_if.i_DM_wen  = 1'b1;
    #1;
    total++; if (bus_if.o_con_valid !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", bus_if.o_con_valid); end
    @(negedge clk);
    bus_if.i_DM_wen = 1'b0;
    #1;
    total++; if (bus_if.o_con_valid !== 1'b1 || bus_if.o_con_data !== 8'h41) begin
      bad++; $display("FAIL first_byte got=%b/%h exp=1/41", bus_if.o_con_valid, bus_if.o_con_data); end
    for (int b = 8'h42; b <= 8'h48; b++) wr(A_CON, data_t'(b));
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0801) begin bad++; $display("FAIL full_status got=%h exp=00000801", d); end
    rd(A_CON, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL con_data_rd got=%h exp=0", d); end
    wr(A_CON, 32'h49);
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0805) begin bad++; $display("FAIL ovf_status got=%h exp=00000805", d); end
    total++; if (bus_if.o_con_data !== 8'h41) begin bad++; $display("FAIL ovf_head got=%h exp=41", bus_if.o_con_data); end
    wr(A_ST, 32'h4);
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0801) begin bad++; $display("FAIL ovf_clear got=%h exp=00000801", d); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [8];
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50};
    bus_if.i_DM_addr   = A_CON;
    bus_if.i_DM_wd     = 32'h50;
    bus_if.i_DM_wen    = 1'b1;
    bus_if.i_con_ready = 1'b1;
    #1;
    total++; if (bus_if.o_con_data !== 8'h41) begin bad++; $display("FAIL pp_head got=%h exp=41", bus_if.o_con_data); end
    @(negedge clk);
    bus_if.i_DM_wen    = 1'b0;
    bus_if.i_con_ready = 1'b0;
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0801) begin bad++; $display("FAIL pp_status got=%h exp=00000801", d); end
    bus_if.i_con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (bus_if.o_con_valid !== 1'b1 || bus_if.o_con_data !== exp_q[i]) begin
        bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus_if.o_con_valid, bus_if.o_con_data, exp_q[i]); end
      @(negedge clk);
    end
    bus_if.i_con_ready = 1'b0;
    #1;
    total++; if (bus_if.o_con_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus_if.o_con_valid); end
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL drain_status got=%h exp=00000002", d); end
  endtask

  task automatic test_mid_reset();
    wr(A_CON, 32'h61);
    wr(A_CON, 32'h62);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus_if.o_gpio !== 32'h0) begin bad++; $display("FAIL mid_rst_gpio got=%h exp=0", bus_if.o_gpio); end
    total++; if (bus_if.o_con_valid !== 1'b0 || bus_if.o_con_data !== 8'h00) begin
      bad++; $display("FAIL mid_rst_fifo got=%b/%h exp=0/00", bus_if.o_con_valid, bus_if.o_con_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL mid_rst_status got=%h exp=00000002", d); end
  endtask

`ifdef DM_MISALIGN_CHK_EN
  task automatic test_misalign();
    @(negedge clk);
    bus_if.i_DM_addr = 32'h12;
    bus_if.i_DM_wd   = 32'h1234;
    bus_if.i_DM_wen  = 1'b1;
    #1;
    total++; if (bus_if.o_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", bus_if.o_misalign); end
    @(negedge clk);
    bus_if.i_DM_wen = 1'b0;
    rd(32'h10, d);
    total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_wr_ram got=%h exp=cafef00d", d); end
    rd(32'h11, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mis_rd got=%h exp=0", d); end
    rd(A_ST, d);
    total++; if (d !== 32'h0000_000A) begin bad++; $display("FAIL mis_status got=%h exp=0000000a", d); end
    wr(A_CON + 32'h1, 32'h1234);
    #1;
    total++; if (bus_if.o_con_valid !== 1'b0) begin bad++; $display("FAIL mis_push got=%b exp=0", bus_if.o_con_valid); end
    wr(A_GPIO + 32'h2, 32'hFFFF_FFFF);
    #1;
    total++; if (bus_if.o_gpio !== 32'h0) begin bad++; $display("FAIL mis_gpio got=%h exp=0", bus_if.o_gpio); end
    wr(A_ST, 32'h8);
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL mis_clear got=%h exp=00000002", d); end
  endtask
`endif

  task automatic test_status_write();
    @(negedge clk);
    wr(A_ST, 32'hFFFF_FFFF);
    rd(A_ST, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL status_wr got=%h exp=00000002", d); end
  endtask

  initial begin
    test_reset();
    test_cycle_wrap();
    test_ram();
    test_rw_same();
    test_gpio();
    test_fifo_fill();
    test_push_pop_full();
    test_mid_reset();
`ifdef DM_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_status_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
